// File: rtl/data_axi_pkg.sv
// Shared types and AXI constants for the data-side AXI bridge.
// State encoding, burst/size/cache codes and the byte-enable to AXSIZE map.
package data_axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP,
    RESP
  } state_t;

  localparam logic [7:0] LEN_SINGLE = 8'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_1B    = 3'd0;
  localparam logic [2:0] SIZE_2B    = 3'd1;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [3:0] CACHE_ALL  = 4'b1111;
  localparam logic [3:0] CACHE_NONE = 4'b0000;

  // Patterns outside the legal set fall back to a full-word size.
  function automatic logic [2:0] wsel_size(input logic [3:0] wsel);
    logic [2:0] sz;
    unique case (1'b1)
      (wsel == 4'b0011),
      (wsel == 4'b1100): sz = SIZE_2B;
      (wsel == 4'b0001),
      (wsel == 4'b0010),
      (wsel == 4'b0100),
      (wsel == 4'b1000): sz = SIZE_1B;
      default:           sz = SIZE_4B;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/data_axi_bridge_if.sv
// Single-beat AXI4 bus bundle (AR/R/AW/W/B) between bridge and memory side.
// master: bridge drives addresses/data/readys; slave: memory side.
interface data_axi_bridge_if
  import data_axi_pkg::*;
#(
  parameter int ID_W = 4
);

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [3:0]        awcache;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize,
    output arburst, arcache, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize,
    output awburst, awcache, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize,
    input  arburst, arcache, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize,
    input  awburst, awcache, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/data_axi_bridge.sv
// Core data-port to single-beat AXI4 bridge, one transaction in flight.
// Ports: clk/resetn, core req (ren/wen/wsel/addr/wdata/cached/flush),
// core completion (rdata/rvalid/bvalid), axi (master modport).
module data_axi_bridge
  import data_axi_pkg::*;
#(
  parameter int ID_W = 4,
  parameter logic [ID_W-1:0] RD_ID = '0,
  parameter logic [ID_W-1:0] WR_ID = ID_W'(1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_axi_ren,
  input  logic              data_axi_wen,
  input  logic [3:0]        data_axi_wsel,
  input  logic [ADDR_W-1:0] data_axi_addr,
  input  logic [DATA_W-1:0] data_axi_wdata,
  input  logic              cached_trans,
  input  logic              axi_flush,
  output logic [DATA_W-1:0] data_axi_rdata,
  output logic              data_axi_rvalid,
  output logic              data_axi_bvalid,
  data_axi_bridge_if.master axi
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0] wsel_q, wsel_d;
  logic [3:0] cache_q, cache_d;
  logic drop_q, drop_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;
  logic rpulse_q, rpulse_d;
  logic bpulse_q, bpulse_d;

  logic aw_hs, w_hs;
  logic unused_ok;

  assign aw_hs = awvalid_q & axi.awready;
  assign w_hs  = wvalid_q & axi.wready;

  // Response status and IDs are not acted upon.
  assign unused_ok = ^{axi.rid, axi.rresp, axi.rlast,
                       axi.bid, axi.bresp};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wsel_d    = wsel_q;
    cache_d   = cache_q;
    drop_d    = drop_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    rpulse_d  = 1'b0;
    bpulse_d  = 1'b0;

    if (axi_flush && state_q != IDLE) drop_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!axi_flush &&
            (data_axi_wen || data_axi_ren)) begin
          addr_d  = data_axi_addr;
          cache_d = cached_trans ? CACHE_ALL
                                 : CACHE_NONE;
          if (data_axi_wen) begin
            wdata_d   = data_axi_wdata;
            wsel_d    = data_axi_wsel;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi.rvalid) begin
          rready_d = 1'b0;
          rdata_d  = axi.rdata;
          rpulse_d = !(drop_q || axi_flush);
          state_d  = RESP;
        end
      end
      WR_ADDR_DATA: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) &&
            (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          bready_d = 1'b0;
          bpulse_d = !(drop_q || axi_flush);
          state_d  = RESP;
        end
      end
      RESP: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wsel_q    <= '0;
      cache_q   <= '0;
      drop_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      rpulse_q  <= 1'b0;
      bpulse_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wsel_q    <= wsel_d;
      cache_q   <= cache_d;
      drop_q    <= drop_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      rpulse_q  <= rpulse_d;
      bpulse_q  <= bpulse_d;
    end
  end

  assign data_axi_rdata  = rdata_q;
  assign data_axi_rvalid = rpulse_q;
  assign data_axi_bvalid = bpulse_q;

  assign axi.arid    = RD_ID;
  assign axi.araddr  = {addr_q[31:2], 2'b00};
  assign axi.arlen   = LEN_SINGLE;
  assign axi.arsize  = SIZE_4B;
  assign axi.arburst = BURST_INCR;
  assign axi.arcache = cache_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = WR_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = LEN_SINGLE;
  assign axi.awsize  = wsel_size(wsel_q);
  assign axi.awburst = BURST_INCR;
  assign axi.awcache = cache_q;
  assign axi.awvalid = awvalid_q;

  assign axi.wdata  = wdata_q;
  assign axi.wstrb  = wsel_q;
  assign axi.wlast  = 1'b1;
  assign axi.wvalid = wvalid_q;
  assign axi.bready = bready_q;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Scoreboard bench for data_axi_bridge: random AXI slave, expected-queue
// monitor, directed latency/flush/reset cases plus a random phase.
module tb_data_axi_bridge;

  localparam int ID_W = 4;
  localparam logic [3:0] RD_ID = 4'd0;
  localparam logic [3:0] WR_ID = 4'd1;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    int          cyc;
  } cmp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  wsel = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        cached = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        bvalid_o;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_done = 0;
  int n_aw = 0;
  int cyc = 0;

  int ar_pct = 100, aw_pct = 100, w_pct = 100;
  int r_min = 0, r_max = 0, b_min = 0, b_max = 0;

  logic [52:0] exp_ar[$];
  logic [52:0] exp_aw[$];
  logic [36:0] exp_w[$];
  cmp_t        exp_cmp[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_axi_bridge_if #(.ID_W(ID_W)) axi ();

  data_axi_bridge #(
    .ID_W(ID_W), .RD_ID(RD_ID), .WR_ID(WR_ID)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .data_axi_ren(ren),
    .data_axi_wen(wen),
    .data_axi_wsel(wsel),
    .data_axi_addr(addr),
    .data_axi_wdata(wdata),
    .cached_trans(cached),
    .axi_flush(flush),
    .data_axi_rdata(rdata_o),
    .data_axi_rvalid(rvalid_o),
    .data_axi_bvalid(bvalid_o),
    .axi(axi)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h1FC0_0004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [2:0] exp_size(input logic [3:0] s);
    int n;
    n = $countones(s);
    if (n == 4) return 3'd2;
    if (n == 2) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [52:0] ar_word(input logic [31:0] a,
                                          input bit c);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    return {RD_ID, wa, 8'h00, 3'd2, 2'b01, c ? 4'hF : 4'h0};
  endfunction

  function automatic logic [52:0] aw_word(input logic [31:0] a,
                                          input logic [3:0] s,
                                          input bit c);
    return {WR_ID, a, 8'h00, exp_size(s), 2'b01,
            c ? 4'hF : 4'h0};
  endfunction

  function automatic bit rdy(input int pct);
    return int'($urandom_range(100, 1)) <= pct;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got nothing or unexpected event", nm);
  endtask

  // AXI slave: drives at negedge; handshake flags are decided after
  // the drives settle and consumed on the following negedge.
  initial begin
    bit ar_f, r_f, aw_f, w_f, b_f;
    bit rd_pend, aw_got, w_got;
    int rd_cnt, b_cnt;
    logic [31:0] ar_cap;
    {ar_f, r_f, aw_f, w_f, b_f} = '0;
    {rd_pend, aw_got, w_got} = '0;
    rd_cnt = 0; b_cnt = 0; ar_cap = '0;
    axi.arready = 0; axi.awready = 0; axi.wready = 0;
    axi.rvalid = 0; axi.rdata = '0; axi.rid = '0;
    axi.rresp = '0; axi.rlast = 0;
    axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        {ar_f, r_f, aw_f, w_f, b_f} = '0;
        {rd_pend, aw_got, w_got} = '0;
        axi.arready = 0; axi.awready = 0; axi.wready = 0;
        axi.rvalid = 0; axi.bvalid = 0;
        continue;
      end
      if (ar_f) begin
        rd_pend = 1;
        rd_cnt = int'($urandom_range(r_max, r_min));
      end
      if (r_f) begin axi.rvalid = 0; n_done++; end
      if (aw_f) begin aw_got = 1; n_aw++; end
      if (w_f) w_got = 1;
      if ((aw_f || w_f) && aw_got && w_got)
        b_cnt = int'($urandom_range(b_max, b_min));
      if (b_f) begin axi.bvalid = 0; n_done++; end
      axi.arready = rdy(ar_pct);
      axi.awready = rdy(aw_pct);
      axi.wready  = rdy(w_pct);
      if (rd_pend && !axi.rvalid) begin
        if (rd_cnt == 0) begin
          axi.rvalid = 1;
          axi.rdata = mem_rd(ar_cap);
          axi.rid = RD_ID;
          axi.rresp = 2'($urandom);
          axi.rlast = 1;
          rd_pend = 0;
        end else rd_cnt--;
      end
      if (aw_got && w_got && !axi.bvalid) begin
        if (b_cnt == 0) begin
          axi.bvalid = 1;
          axi.bid = WR_ID;
          axi.bresp = 2'($urandom);
          aw_got = 0;
          w_got = 0;
        end else b_cnt--;
      end
      #1;
      ar_f = axi.arvalid && axi.arready;
      if (ar_f) ar_cap = axi.araddr;
      r_f  = axi.rvalid && axi.rready;
      aw_f = axi.awvalid && axi.awready;
      w_f  = axi.wvalid && axi.wready;
      b_f  = axi.bvalid && axi.bready;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer.
  initial begin
    bit p_ar, p_aw, p_w;
    logic [52:0] ar_now, aw_now, ar_prev, aw_prev;
    logic [36:0] w_now, w_prev;
    cmp_t e;
    p_ar = 0; p_aw = 0; p_w = 0;
    ar_prev = '0; aw_prev = '0; w_prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        p_ar = 0; p_aw = 0; p_w = 0;
        continue;
      end
      ar_now = {axi.arid, axi.araddr, axi.arlen, axi.arsize,
                axi.arburst, axi.arcache};
      aw_now = {axi.awid, axi.awaddr, axi.awlen, axi.awsize,
                axi.awburst, axi.awcache};
      w_now  = {axi.wdata, axi.wstrb, axi.wlast};
      if (p_ar)
        chk("ar_hold", 64'({axi.arvalid, ar_now}),
            64'({1'b1, ar_prev}));
      if (p_aw)
        chk("aw_hold", 64'({axi.awvalid, aw_now}),
            64'({1'b1, aw_prev}));
      if (p_w)
        chk("w_hold", 64'({axi.wvalid, w_now}),
            64'({1'b1, w_prev}));
      if (axi.arvalid && axi.arready) begin
        if (exp_ar.size() == 0) flag("unexpected_ar");
        else chk("ar", 64'(ar_now), 64'(exp_ar.pop_front()));
      end
      if (axi.awvalid && axi.awready) begin
        if (exp_aw.size() == 0) flag("unexpected_aw");
        else chk("aw", 64'(aw_now), 64'(exp_aw.pop_front()));
      end
      if (axi.wvalid && axi.wready) begin
        if (exp_w.size() == 0) flag("unexpected_w");
        else chk("w", 64'(w_now), 64'(exp_w.pop_front()));
      end
      p_ar = axi.arvalid && !axi.arready;
      p_aw = axi.awvalid && !axi.awready;
      p_w  = axi.wvalid && !axi.wready;
      ar_prev = ar_now; aw_prev = aw_now; w_prev = w_now;
      if (rvalid_o || bvalid_o) begin
        n_pulse++;
        if (exp_cmp.size() == 0) flag("unexpected_pulse");
        else begin
          e = exp_cmp.pop_front();
          chk("pulse_kind", 64'({rvalid_o, bvalid_o}),
              64'(e.wr ? 2'b01 : 2'b10));
          if (!e.wr) chk("rdata", 64'(rdata_o), 64'(e.data));
          if (e.cyc >= 0) chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic wait_pulses(input int base, input int n,
                             input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      #3;
      ok = (n_pulse >= base + n);
    end
    if (!ok) flag(nm);
  endtask

  // fmode: 0 normal, 1 flush once the AXI request is visible,
  // 2 flush once the bridge waits for read data.
  task automatic do_txn(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit c, input int fmode, input int lat);
    cmp_t e;
    int base;
    bit ok;
    @(negedge clk);
    if (wr) begin
      exp_aw.push_back(aw_word(a, s, c));
      exp_w.push_back({d, s, 1'b1});
    end else exp_ar.push_back(ar_word(a, c));
    if (fmode == 0) begin
      e.wr = wr;
      e.data = wr ? 32'h0 : mem_rd(a & 32'hFFFF_FFFC);
      e.cyc = (lat >= 0) ? cyc + lat : -1;
      exp_cmp.push_back(e);
    end
    addr = a; wdata = d; wsel = s; cached = c;
    if (wr) wen = 1; else ren = 1;
    if (fmode == 0) begin
      base = n_pulse;
      wait_pulses(base, 1, "timeout_pulse");
    end else begin
      base = n_done;
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
        @(negedge clk);
        #3;
        ok = (fmode == 1) ? (axi.arvalid || axi.awvalid)
                          : axi.rready;
      end
      if (!ok) flag("timeout_flush_point");
      flush = 1; ren = 0; wen = 0;
      @(negedge clk);
      flush = 0;
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
        @(negedge clk);
        ok = (n_done != base);
      end
      if (!ok) flag("timeout_axi_done");
      repeat (3) @(negedge clk);
    end
    ren = 0; wen = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected one");
    $fatal(1, "watchdog");
  end

  initial begin
    cmp_t e;
    int base, t0;
    bit ok;
    logic [3:0] legal [7];
    bit wr, c;
    int fm;
    logic [31:0] a;
    legal = '{4'b1111, 4'b0011, 4'b1100, 4'b0001,
              4'b0010, 4'b0100, 4'b1000};

    repeat (3) @(negedge clk);
    chk("reset_state",
        64'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
             axi.bready, rvalid_o, bvalid_o, rdata_o}), 64'(0));
    resetn = 1;
    @(negedge clk);

    // minimum-latency cached read, then uncached write
    do_txn(0, 32'h1FC0_0004, 32'h0, 4'hF, 1, 0, 3);
    do_txn(1, 32'h0000_1000, 32'h1234_5678, 4'hF, 0, 0, 3);

    // byte write, wready delayed 3 cycles after AW
    w_pct = 0;
    fork
      do_txn(1, 32'h8000_0003, 32'hAB00_0000, 4'b1000, 0, 0, -1);
      begin
        base = n_aw;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
          @(negedge clk);
          ok = (n_aw != base);
        end
        if (!ok) flag("timeout_aw");
        repeat (3) @(negedge clk);
        w_pct = 100;
      end
    join

    // flush while waiting for delayed read data
    r_min = 5; r_max = 5;
    do_txn(0, 32'h1000_0040, 32'h0, 4'hF, 0, 2, -1);
    r_min = 0; r_max = 0;
    do_txn(0, 32'h1000_0044, 32'h0, 4'hF, 0, 0, 3);

    // flush in IDLE delays the request by one cycle
    @(negedge clk);
    t0 = cyc;
    exp_ar.push_back(ar_word(32'h0000_2008, 0));
    e.wr = 0; e.data = mem_rd(32'h0000_2008); e.cyc = t0 + 4;
    exp_cmp.push_back(e);
    addr = 32'h0000_2008; cached = 0; ren = 1; flush = 1;
    @(negedge clk);
    flush = 0;
    wait_pulses(n_pulse, 1, "timeout_idle_flush");
    ren = 0;

    // request held through RESP: exactly two transactions
    @(negedge clk);
    t0 = cyc;
    base = n_pulse;
    for (int k = 0; k < 2; k++) begin
      exp_ar.push_back(ar_word(32'h0000_300C, 1));
      e.wr = 0; e.data = mem_rd(32'h0000_300C);
      e.cyc = t0 + 3 + 4 * k;
      exp_cmp.push_back(e);
    end
    addr = 32'h0000_300E; cached = 1; ren = 1; wen = 0;
    wait_pulses(base, 2, "timeout_hold");
    ren = 0;

    // asynchronous reset while AW/W are pending
    aw_pct = 0; w_pct = 0;
    @(negedge clk);
    addr = 32'h2000_0010; wdata = 32'hCAFE_F00D;
    wsel = 4'hF; cached = 1; wen = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      #3;
      ok = axi.awvalid;
    end
    chk("aw_before_rst", 64'({axi.awvalid, axi.wvalid}), 64'(2'b11));
    resetn = 0;
    #1;
    chk("rst_abort",
        64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
             axi.rready, rvalid_o, bvalid_o}), 64'(0));
    wen = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    aw_pct = 100; w_pct = 100;
    do_txn(1, 32'h2000_0016, 32'h0000_BEEF, 4'b1100, 0, 0, 3);

    // randomized phase
    for (int n = 0; n < 60; n++) begin
      ar_pct = int'($urandom_range(100, 30));
      aw_pct = int'($urandom_range(100, 30));
      w_pct  = int'($urandom_range(100, 30));
      r_max  = int'($urandom_range(4, 0));
      b_max  = int'($urandom_range(4, 0));
      wr = 1'($urandom);
      c  = 1'($urandom);
      a  = $urandom;
      fm = 0;
      if ($urandom_range(7, 0) == 0)
        fm = wr ? 1 : int'($urandom_range(2, 1));
      do_txn(wr, a, $urandom, legal[$urandom_range(6, 0)],
             c, fm, -1);
    end

    repeat (5) @(negedge clk);
    chk("leftover_expect",
        64'(exp_ar.size() + exp_aw.size() +
            exp_w.size() + exp_cmp.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
